// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM state
// encoding and the parity helper used when a word is latched.
package uart_pkg;

  localparam int PAR_NONE      = 0;
  localparam int PAR_ODD       = 1;
  localparam int PAR_EVEN      = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Caller zero-extends the word, so unused upper bits never flip the result.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) p = ~p;
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// Fractional baud-rate generator: accumulates BAUD each cycle and emits a tick
// whenever the running sum crosses CLK_HZ, so bit lengths never drift.
module uart_baud_nco #(
  parameter int CLK_HZ = 40_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam logic [ACC_W-1:0] STEP = ACC_W'(BAUD);
  localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLK_HZ - BAUD);

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    tick  = 1'b0;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      // acc + BAUD - CLK_HZ, written as a single subtract of the constant
      if (acc_q >= WRAP) begin
        tick  = 1'b1;
        acc_d = acc_q - WRAP;
      end else begin
        acc_d = acc_q + STEP;
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) acc_q <= '0;
    else           acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an inline circular FIFO and NCO bit timing.
// Frame: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 40_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          uart_wr_i,
  input  logic [DATA_BITS-1:0]          uart_dat_i,
  output logic                          uart_full_o,
  output logic                          uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
  output logic                          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  // FIFO: pointers carry one extra wrap bit so full and empty are distinct
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [LW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level, level_d;
  logic                 full_q, full_d;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // Transmit FSM state
  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 tick;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign head     = fifo_mem[rd_ptr_q[AW-1:0]];
  assign head_par = parity_bit(MAX_DATA_BITS'(head), PARITY);
  assign push     = uart_wr_i && !full_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + LW'(push);
    rd_ptr_d = rd_ptr_q + LW'(pop);
    level_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (level_d == DEPTH_L);
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= uart_dat_i;
  end

  uart_baud_nco #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_nco (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .run       (state_q != ST_IDLE),
    .clear     (state_q == ST_IDLE),
    .tick      (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (level != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            // back-to-back frames: next start bit follows the last stop bit directly
            if (level != '0) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = head_par;
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
    end
  end

  assign uart_full_o  = full_q;
  assign uart_level_o = level;
  assign uart_busy    = (state_q != ST_IDLE) || (level != '0);
  assign uart_tx      = tx_q;

endmodule
